// File: rtl/d_mem_sized_if.sv
// rtl/d_mem_sized_if.sv - request/response bundle for the sized MIPS data memory
// Purpose: groups the MEM-stage request signals (Address, WriteData, MemRead,
//          MemWrite, Size, Unsigned) and the memory responses (Ready, ReadData,
//          ReadValid, Fault).
// Modports: master = pipeline side (drives requests), slave = memory side.
interface d_mem_sized_if;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  Size;
   logic        Unsigned;
   logic        Ready;
   logic [31:0] ReadData;
   logic        ReadValid;
   logic        Fault;

   modport master (
      output Address, WriteData, MemRead, MemWrite, Size, Unsigned,
      input  Ready, ReadData, ReadValid, Fault
   );

   modport slave (
      input  Address, WriteData, MemRead, MemWrite, Size, Unsigned,
      output Ready, ReadData, ReadValid, Fault
   );
endinterface

// File: rtl/d_mem_sized.sv
// rtl/d_mem_sized.sv - byte-addressed MIPS data memory with sized accesses and registered reads
// Purpose: 2**ADDR_WIDTH x 32-bit little-endian data memory supporting byte,
//          halfword and word loads/stores with sign/zero extension. Reads return
//          LATENCY cycles after acceptance with a ReadValid pulse; illegal
//          requests are dropped and flagged with a one-cycle Fault pulse.
// Ports:   clock - rising-edge clock
//          reset - synchronous active-high reset (array contents are kept)
//          bus   - d_mem_sized_if.slave request/response bundle
module d_mem_sized #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 1
) (
   input  logic           clock,
   input  logic           reset,
   d_mem_sized_if.slave   bus
);
   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [31:0] mem_q [2**ADDR_WIDTH];

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] read_data_q, read_data_d;
   logic        read_valid_q, read_valid_d;
   logic        fault_q, fault_d;

   logic                  ready;
   logic                  accept;
   logic                  illegal;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [1:0]            lane;
   logic [31:0]           word_rd;
   logic [31:0]           shifted;
   logic [31:0]           load_result;
   logic [3:0]            byte_en;
   logic [31:0]           wdata_lanes;
   logic                  mem_we;

   assign ready    = (state_q == IDLE) && !reset;
   assign accept   = ready && (bus.MemRead || bus.MemWrite);
   assign word_idx = bus.Address[ADDR_WIDTH+1:2];
   assign lane     = bus.Address[1:0];

   // Shift form of the upper-address check stays legal even when no
   // upper bits exist.
   assign illegal = (bus.MemRead && bus.MemWrite)
                 || (bus.Size == 2'b11)
                 || (bus.Size == SZ_HALF && bus.Address[0])
                 || (bus.Size == SZ_WORD && bus.Address[1:0] != 2'b00)
                 || ((bus.Address >> (ADDR_WIDTH + 2)) != 32'd0);

   // Array is sampled before the same-edge write lands, so a read always
   // sees pre-write contents.
   assign word_rd = mem_q[word_idx];
   assign shifted = word_rd >> {lane, 3'b000};

   always_comb begin
      load_result = word_rd;
      case (bus.Size)
         SZ_BYTE: load_result = bus.Unsigned ? {24'd0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_result = bus.Unsigned ? {16'd0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
         default: load_result = word_rd;
      endcase
   end

   // Store data is replicated across lanes; byte_en picks the live ones.
   always_comb begin
      byte_en     = 4'b0000;
      wdata_lanes = bus.WriteData;
      case (bus.Size)
         SZ_BYTE: begin
            byte_en     = 4'b0001 << lane;
            wdata_lanes = {4{bus.WriteData[7:0]}};
         end
         SZ_HALF: begin
            byte_en     = lane[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{bus.WriteData[15:0]}};
         end
         SZ_WORD: byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   end

   assign mem_we = accept && bus.MemWrite && !illegal;

   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem_q[word_idx][b*8 +: 8] <= wdata_lanes[b*8 +: 8];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      read_data_d  = read_data_q;
      read_valid_d = 1'b0;
      fault_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (illegal) begin
                  fault_d = 1'b1;
               end else if (bus.MemRead) begin
                  if (LATENCY <= 1) begin
                     read_valid_d = 1'b1;
                     read_data_d  = load_result;
                  end else begin
                     state_d = WAIT;
                     cnt_d   = 3'(LATENCY - 1);
                     hold_d  = load_result;
                  end
               end
            end
         end
         WAIT: begin
            // Counter hitting zero on this edge makes the next cycle the
            // ReadValid cycle, which is already back in IDLE.
            if (cnt_q <= 3'd1) begin
               state_d      = IDLE;
               cnt_d        = 3'd0;
               read_valid_d = 1'b1;
               read_data_d  = hold_q;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         hold_q       <= 32'd0;
         read_data_q  <= 32'd0;
         read_valid_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
         fault_q      <= fault_d;
      end
   end

   assign bus.Ready     = ready;
   assign bus.ReadData  = read_data_q;
   assign bus.ReadValid = read_valid_q;
   assign bus.Fault     = fault_q;
endmodule

// File: tb/tb_d_mem_sized.sv
// tb/tb_d_mem_sized.sv - directed self-checking bench for d_mem_sized at latencies 1, 3 and 4
module tb_d_mem_sized;
   logic clock;
   logic reset;
   int   vectors = 0;
   int   errors  = 0;

   d_mem_sized_if bus1 ();
   d_mem_sized_if bus3 ();
   d_mem_sized_if bus4 ();

   d_mem_sized #(.ADDR_WIDTH(8), .LATENCY(1)) u1 (.clock(clock), .reset(reset), .bus(bus1));
   d_mem_sized #(.ADDR_WIDTH(8), .LATENCY(3)) u3 (.clock(clock), .reset(reset), .bus(bus3));
   d_mem_sized #(.ADDR_WIDTH(8), .LATENCY(4)) u4 (.clock(clock), .reset(reset), .bus(bus4));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic drive(input int w, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic u);
      case (w)
         1: begin
            bus1.MemRead = rd; bus1.MemWrite = wr; bus1.Address = a;
            bus1.WriteData = d; bus1.Size = sz; bus1.Unsigned = u;
         end
         3: begin
            bus3.MemRead = rd; bus3.MemWrite = wr; bus3.Address = a;
            bus3.WriteData = d; bus3.Size = sz; bus3.Unsigned = u;
         end
         default: begin
            bus4.MemRead = rd; bus4.MemWrite = wr; bus4.Address = a;
            bus4.WriteData = d; bus4.Size = sz; bus4.Unsigned = u;
         end
      endcase
   endtask

   task automatic idle(input int w);
      drive(w, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
   endtask

   // One-edge write on the L=1 instance, leaving the bus idle afterwards.
   task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      drive(1, 1'b0, 1'b1, a, d, sz, 1'b0);
      cyc();
      idle(1);
   endtask

   // One-edge read on the L=1 instance; result is checked the cycle after.
   task automatic rd1(input string tag, input logic [31:0] a, input logic [1:0] sz,
                      input logic u, input logic [31:0] exp);
      drive(1, 1'b1, 1'b0, a, 32'd0, sz, u);
      cyc();
      idle(1);
      chk({tag, "_valid"}, {31'd0, bus1.ReadValid}, 32'd1);
      chk({tag, "_data"}, bus1.ReadData, exp);
   endtask

   // Drive an illegal request on L=1 and expect only a Fault pulse.
   task automatic fault1(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [1:0] sz);
      drive(1, rd, wr, a, 32'h0000_0000, sz, 1'b0);
      cyc();
      idle(1);
      chk({tag, "_fault"}, {31'd0, bus1.Fault}, 32'd1);
      chk({tag, "_novalid"}, {31'd0, bus1.ReadValid}, 32'd0);
      cyc();
      chk({tag, "_fault_pulse"}, {31'd0, bus1.Fault}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      idle(1);
      idle(3);
      idle(4);
      cyc();
      cyc();
      chk("rst_ready", {31'd0, bus1.Ready}, 32'd0);
      chk("rst_rdata", bus1.ReadData, 32'd0);
      chk("rst_rvalid", {31'd0, bus1.ReadValid}, 32'd0);
      chk("rst_fault", {31'd0, bus1.Fault}, 32'd0);
      reset = 1'b0;
      cyc();
      chk("ready_after_rst", {31'd0, bus1.Ready}, 32'd1);

      // Word write/read at latency 1
      wr1(32'h10, 32'hDEAD_BEEF, 2'b10);
      chk("wr_ready", {31'd0, bus1.Ready}, 32'd1);
      rd1("word10", 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF);
      chk("word10_ready", {31'd0, bus1.Ready}, 32'd1);
      cyc();
      chk("rvalid_pulse", {31'd0, bus1.ReadValid}, 32'd0);
      chk("rdata_hold", bus1.ReadData, 32'hDEAD_BEEF);

      // Byte lanes and extension
      wr1(32'h20, 32'h0000_0000, 2'b10);
      wr1(32'h21, 32'h1234_5680, 2'b00);
      rd1("byte_word", 32'h20, 2'b10, 1'b0, 32'h0000_8000);
      rd1("byte_s", 32'h21, 2'b00, 1'b0, 32'hFFFF_FF80);
      rd1("byte_u", 32'h21, 2'b00, 1'b1, 32'h0000_0080);
      wr1(32'h22, 32'hABCD_8001, 2'b01);
      rd1("half_s", 32'h22, 2'b01, 1'b0, 32'hFFFF_8001);
      rd1("half_u", 32'h22, 2'b01, 1'b1, 32'h0000_8001);
      rd1("half_word", 32'h20, 2'b10, 1'b1, 32'h8001_8000);

      // Back-to-back reads on consecutive edges
      wr1(32'h0, 32'hA0A0_A0A0, 2'b10);
      wr1(32'h4, 32'hB1B1_B1B1, 2'b10);
      wr1(32'h8, 32'hC2C2_C2C2, 2'b10);
      drive(1, 1'b1, 1'b0, 32'h0, 32'd0, 2'b10, 1'b0);
      cyc();
      chk("b2b0_valid", {31'd0, bus1.ReadValid}, 32'd1);
      chk("b2b0_data", bus1.ReadData, 32'hA0A0_A0A0);
      drive(1, 1'b1, 1'b0, 32'h4, 32'd0, 2'b10, 1'b0);
      cyc();
      chk("b2b1_valid", {31'd0, bus1.ReadValid}, 32'd1);
      chk("b2b1_data", bus1.ReadData, 32'hB1B1_B1B1);
      drive(1, 1'b1, 1'b0, 32'h8, 32'd0, 2'b10, 1'b0);
      cyc();
      idle(1);
      chk("b2b2_valid", {31'd0, bus1.ReadValid}, 32'd1);
      chk("b2b2_data", bus1.ReadData, 32'hC2C2_C2C2);

      // Faults: request dropped, target word untouched
      fault1("f_word_unal", 1'b1, 1'b0, 32'h2, 2'b10);
      fault1("f_half_unal", 1'b0, 1'b1, 32'h5, 2'b01);
      rd1("f_half_keep", 32'h4, 2'b10, 1'b0, 32'hB1B1_B1B1);
      fault1("f_size11", 1'b0, 1'b1, 32'h8, 2'b11);
      rd1("f_size_keep", 32'h8, 2'b10, 1'b0, 32'hC2C2_C2C2);
      fault1("f_rdwr", 1'b1, 1'b1, 32'h10, 2'b10);
      rd1("f_rdwr_keep", 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF);
      fault1("f_range", 1'b0, 1'b1, 32'h400, 2'b10);
      rd1("f_range_keep", 32'h0, 2'b10, 1'b0, 32'hA0A0_A0A0);

      // Latency 3 handshake
      drive(3, 1'b0, 1'b1, 32'h0, 32'h3333_3333, 2'b10, 1'b0);
      cyc();
      chk("l3_wr_ready", {31'd0, bus3.Ready}, 32'd1);
      drive(3, 1'b1, 1'b0, 32'h0, 32'd0, 2'b10, 1'b0);
      cyc();
      drive(3, 1'b0, 1'b1, 32'h0, 32'h0000_0BAD, 2'b10, 1'b0);
      chk("l3_busy1_ready", {31'd0, bus3.Ready}, 32'd0);
      chk("l3_busy1_valid", {31'd0, bus3.ReadValid}, 32'd0);
      cyc();
      chk("l3_busy2_ready", {31'd0, bus3.Ready}, 32'd0);
      chk("l3_busy2_valid", {31'd0, bus3.ReadValid}, 32'd0);
      cyc();
      chk("l3_valid", {31'd0, bus3.ReadValid}, 32'd1);
      chk("l3_data", bus3.ReadData, 32'h3333_3333);
      chk("l3_valid_ready", {31'd0, bus3.Ready}, 32'd1);
      drive(3, 1'b1, 1'b0, 32'h0, 32'd0, 2'b10, 1'b0);
      cyc();
      idle(3);
      chk("l3_re_accept", {31'd0, bus3.Ready}, 32'd0);
      cyc();
      cyc();
      chk("l3_valid2", {31'd0, bus3.ReadValid}, 32'd1);
      chk("l3_ignored_wr", bus3.ReadData, 32'h3333_3333);

      // Latency 4 with reset mid-read
      drive(4, 1'b0, 1'b1, 32'h0, 32'h4444_4444, 2'b10, 1'b0);
      cyc();
      drive(4, 1'b1, 1'b0, 32'h0, 32'd0, 2'b10, 1'b0);
      cyc();
      idle(4);
      reset = 1'b1;
      cyc();
      chk("l4_rst_ready", {31'd0, bus4.Ready}, 32'd0);
      chk("l4_rst_rdata", bus4.ReadData, 32'd0);
      reset = 1'b0;
      #1;
      chk("l4_ready_after", {31'd0, bus4.Ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("l4_no_valid", {31'd0, bus4.ReadValid}, 32'd0);
      end
      chk("l4_rdata_zero", bus4.ReadData, 32'd0);
      drive(4, 1'b1, 1'b0, 32'h0, 32'd0, 2'b10, 1'b0);
      cyc();
      idle(4);
      cyc();
      cyc();
      chk("l4_wait_valid", {31'd0, bus4.ReadValid}, 32'd0);
      cyc();
      chk("l4_valid", {31'd0, bus4.ReadValid}, 32'd1);
      chk("l4_data_kept", bus4.ReadData, 32'h4444_4444);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/d_mem_sized.md
Name: d_mem_sized

Overview:
Parametrised MIPS data memory that replaces the single-word, combinational-read data memory. It adds byte addressing and byte/halfword/word access sizes with sign or zero extension. Reads are registered, with a configurable latency and a Ready/ReadValid handshake. Illegal accesses are reported on a Fault pulse. It sits in the MEM stage between the ALU result and the writeback mux.

Parameters:
ADDR_WIDTH, 8, word-address bits; depth = 2**ADDR_WIDTH 32-bit words (byte space 2**(ADDR_WIDTH+2)).
LATENCY, 1, read latency in cycles from accept edge to ReadValid; legal range 1..4.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
Address  input  32  byte address
WriteData  input  32  store data, right-justified (byte in [7:0], half in [15:0])
MemRead  input  1  read request
MemWrite  input  1  write request
Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
Unsigned  input  1  1 = zero-extend sub-word loads, 0 = sign-extend
Ready  output  1  block accepts a request this cycle
ReadData  output  32  extended load result
ReadValid  output  1  one-cycle pulse: ReadData holds a new load result
Fault  output  1  one-cycle pulse: previous accepted request was illegal and was dropped

Behaviour:
- Interface: one clock, `clock`. Reset is `reset`, synchronous and active-high. The memory array is not cleared by reset.
- Reset values: ReadData=0, ReadValid=0, Fault=0, wait counter=0, state=IDLE.
- Ready = (state==IDLE) && !reset, and is combinational.
- Accept: a request (MemRead|MemWrite) is accepted on a rising edge where Ready=1. Requests with Ready=0 are ignored, not queued.
- Word index = Address[ADDR_WIDTH+1:2]. Lane = Address[1:0]. Byte order is little-endian: lane 0 = bits [7:0].
- Fault conditions, checked at accept:
  - MemRead and MemWrite both 1.
  - Size=11.
  - Halfword with Address[0]=1.
  - Word with Address[1:0]!=0.
  - Address[31:ADDR_WIDTH+2] != 0.
- Fault response: no array change, no ReadValid, state stays IDLE. Fault=1 in the cycle after the accept edge.
- Write: executes on the accept edge and updates only the addressed lanes. Ready stays 1 (one write per cycle).
  - Byte writes WriteData[7:0] to lane Address[1:0].
  - Half writes WriteData[15:0] to lanes {Address[1],0}+1..{Address[1],0}.
  - Word writes all 4 lanes.
- Read: the array is sampled at the accept edge. The addressed field is shifted down and extended by Size/Unsigned, then carried through the latency pipeline.
- Read timing: ReadValid=1 and ReadData=result in the cycle after edge E0+LATENCY-1, where E0 is the accept edge.
- State machine:
  - IDLE to WAIT on an accepted legal read when LATENCY>1. The counter loads LATENCY-1 and decrements each edge.
  - WAIT to IDLE when the counter reaches 0. The ReadValid cycle is an IDLE cycle, so Ready=1 there and back-to-back reads are allowed.
  - Ready=0 for exactly LATENCY-1 cycles per read.
  - LATENCY=1 never leaves IDLE, giving full throughput.
- ReadData holds its last value until the next ReadValid; it is not forced to z.
- Read then write to the same word in the next legal accept: the read returns pre-write data, which is guaranteed because sampling happens at accept.
- Reset mid-read: the pending read is discarded, ReadValid is never raised for it, and the block is Ready the cycle after reset deasserts.
- Unused Size/Unsigned on writes is ignored. Unsigned on word reads is ignored.

Test Plan:
- Word write/read (LATENCY=1): write 0xDEADBEEF @0x10, then read word @0x10 → ReadValid one cycle after the read edge, ReadData=0xDEADBEEF, Ready never drops.
- Byte lanes and extension: write byte 0x80 @0x21 over a word of 0 → word @0x20 reads 0x00008000. Signed byte read @0x21 gives 0xFFFFFF80; unsigned gives 0x00000080. Half 0x8001 @0x22 read signed gives 0xFFFF8001.
- Faults: each of the following → Fault pulse one cycle later, no ReadValid, target word unchanged:
  - Word read @0x02.
  - Half write @0x05.
  - Size=11.
  - MemRead=MemWrite=1.
  - Address bit ADDR_WIDTH+2 set.
- Latency handshake (LATENCY=3): read @0x0 accepted at E0 → Ready=0 for 2 cycles, ReadValid after edge E0+2. A request held during Ready=0 is ignored. A read issued in the ReadValid cycle is accepted.
- Back-to-back (LATENCY=1): reads @0x0,0x4,0x8 on consecutive edges → three consecutive ReadValid pulses with matching data in order.
- Reset mid-read (LATENCY=4): assert reset one cycle after accept → no ReadValid, ReadData=0, Ready=1 the cycle after reset falls, previously written data still readable.
